// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one external ALU.
// Each request is accepted in IDLE, executes for one cycle and is held in RESP until the consumer takes it.
module alu_arbiter (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [1:0]  iReqValid,
  input  logic [31:0] iReqA0,
  input  logic [31:0] iReqB0,
  input  logic [31:0] iReqA1,
  input  logic [31:0] iReqB1,
  input  logic [2:0]  iReqCtrl0,
  input  logic [2:0]  iReqCtrl1,
  output logic [1:0]  oReqReady,
  output logic [31:0] oAluA,
  output logic [31:0] oAluB,
  output logic [2:0]  oAluCtrl,
  input  logic [31:0] iAluRes,
  input  logic        iAluZero,
  output logic        oRespValid,
  output logic        oRespId,
  output logic [31:0] oRespRes,
  output logic        oRespZero,
  output logic        oRespErr,
  input  logic        iRespReady
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        ptr_r;
  logic        grant_s;
  logic        accept_s;
  logic        legal_s;
  logic [31:0] sel_a_s;
  logic [31:0] sel_b_s;
  logic [2:0]  sel_ctrl_s;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  ctrl_r;
  logic        id_r;
  logic        resp_id_r;
  logic [31:0] resp_res_r;
  logic        resp_zero_r;
  logic        resp_err_r;

  function automatic logic is_legal(input logic [2:0] ctrl);
    logic ok;
    case (ctrl)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Grant selection and operand mux for the requester that would be accepted
  always_comb begin
    grant_s = 1'b0;
    case (iReqValid)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = ptr_r;
      default: grant_s = 1'b0;
    endcase
    accept_s = (state_r == IDLE) && (iReqValid != 2'b00) && !iReset;
    if (grant_s) begin
      sel_a_s    = iReqA1;
      sel_b_s    = iReqB1;
      sel_ctrl_s = iReqCtrl1;
    end else begin
      sel_a_s    = iReqA0;
      sel_b_s    = iReqB0;
      sel_ctrl_s = iReqCtrl0;
    end
    legal_s = is_legal(sel_ctrl_s);
  end

  // Next-state logic; illegal ops bypass EXEC so the ALU never sees them
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (legal_s) begin
            state_next_s = EXEC;
          end else begin
            state_next_s = RESP;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (iRespReady) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch, round-robin pointer and response capture
  always_ff @(posedge iClk) begin
    if (iReset) begin
      ptr_r       <= 1'b0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      ctrl_r      <= 3'b000;
      id_r        <= 1'b0;
      resp_id_r   <= 1'b0;
      resp_res_r  <= 32'd0;
      resp_zero_r <= 1'b0;
      resp_err_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        a_r    <= sel_a_s;
        b_r    <= sel_b_s;
        ctrl_r <= sel_ctrl_s;
        id_r   <= grant_s;
        ptr_r  <= ~grant_s;
        if (!legal_s) begin
          resp_id_r   <= grant_s;
          resp_res_r  <= 32'd0;
          resp_zero_r <= 1'b0;
          resp_err_r  <= 1'b1;
        end
      end
      if (state_r == EXEC) begin
        resp_id_r   <= id_r;
        resp_res_r  <= iAluRes;
        resp_zero_r <= iAluZero;
        resp_err_r  <= 1'b0;
      end
    end
  end

  // Handshake and shared-ALU outputs
  always_comb begin
    oReqReady = 2'b00;
    if (accept_s) begin
      oReqReady = grant_s ? 2'b10 : 2'b01;
    end else begin
      oReqReady = 2'b00;
    end
    if ((state_r == EXEC) && !iReset) begin
      oAluA    = a_r;
      oAluB    = b_r;
      oAluCtrl = ctrl_r;
    end else begin
      oAluA    = 32'd0;
      oAluB    = 32'd0;
      oAluCtrl = 3'b000;
    end
  end

  assign oRespValid = (state_r == RESP);
  assign oRespId    = resp_id_r;
  assign oRespRes   = resp_res_r;
  assign oRespZero  = resp_zero_r;
  assign oRespErr   = resp_err_r;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have no parameters; data width fixed at 32, requester count fixed at 2.
REQ-002 iClk  input  1  sole clock; all state updates on rising edge.
REQ-003 iReset  input  1  synchronous, active-high reset, sampled on rising edge of iClk.
REQ-004 iReqValid  input  2  per-requester request valid; bit i = requester i.
REQ-005 iReqA0, iReqB0, iReqA1, iReqB1  input  32 each  operands of requester 0 / 1.
REQ-006 iReqCtrl0, iReqCtrl1  input  3 each  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-007 oReqReady  output  2  request accepted this cycle; bit i = requester i.
REQ-008 oAluA, oAluB  output  32 each  operands driven to shared ALU.
REQ-009 oAluCtrl  output  3  op code driven to shared ALU.
REQ-010 iAluRes  input  32; iAluZero  input  1: combinational ALU result and zero flag.
REQ-011 oRespValid  output  1; oRespId  output  1 (requester served); oRespRes  output  32; oRespZero  output  1; oRespErr  output  1 (illegal op).
REQ-012 iRespReady  input  1  consumer accepts response.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, RESP; encoding free.
REQ-014 IDLE: if no iReqValid bit set, stay IDLE; else grant one requester and accept it that cycle.
REQ-015 Grant: only one valid -> that one; both valid -> requester named by priority pointer ptr.
REQ-016 oReqReady[i] SHALL be combinational = (state==IDLE) && granted==i; at most one bit high; never high outside IDLE.
REQ-017 On acceptance, latch A, B, Ctrl, Id of grantee; ptr <= ~grantee (round-robin).
REQ-018 Legal op accepted -> next state EXEC; illegal op (011, 100, 101) -> next state RESP with err=1, res=0, zero=0; ALU never driven for illegal op.
REQ-019 EXEC (exactly one cycle): oAluA/oAluB/oAluCtrl = latched values; iAluRes/iAluZero captured into response registers at end of cycle; next state RESP, err=0.
REQ-020 Outside EXEC, oAluA=0, oAluB=0, oAluCtrl=000.
REQ-021 RESP: oRespValid=1 with oRespId/oRespRes/oRespZero/oRespErr stable; hold until iRespReady=1; on oRespValid&&iRespReady go IDLE.
REQ-022 oRespValid SHALL be 0 in IDLE and EXEC; response fields hold last value when not valid.
REQ-023 Latency: legal op accepted in cycle N -> oRespValid first high in N+2; illegal op -> N+1.
REQ-024 Throughput: max one accepted request per 3 cycles (legal), 2 cycles (illegal), with iRespReady held 1.
REQ-025 No new request accepted in the cycle the response handshakes; next grant earliest in following IDLE cycle.
REQ-026 Requester dropping iReqValid while not granted SHALL be permitted; no request is latched without oReqReady.
REQ-027 Back-pressure: iRespReady=0 stalls indefinitely in RESP; both requesters see oReqReady=0.

Reset
REQ-028 iReset=1 SHALL, at next rising edge, force state IDLE, ptr=0, oRespValid=0, oRespId=0, oRespRes=0, oRespZero=0, oRespErr=0, latched operands=0.
REQ-029 Reset overrides all other inputs, including mid-EXEC or mid-RESP; in-flight request discarded, no response issued.
REQ-030 While iReset=1, oReqReady=00 and ALU outputs=0.

Verification
REQ-031 Single add: iReqValid=01, A0=5, B0=7, Ctrl0=010, iRespReady=1 -> oReqReady=01 at N, oAluCtrl=010 at N+1, oRespValid at N+2 with Id=0, Res=12, Zero=0, Err=0.
REQ-032 Contention: both valid continuously, Ctrl=110, A0=B0=9, A1=3, B1=1 -> grants alternate 0,1,0,1; responses Id0 Res=0 Zero=1, Id1 Res=2 Zero=0.
REQ-033 Back-pressure: hold iRespReady=0 for 5 cycles in RESP -> oRespValid and fields stable, oReqReady=00 throughout; release -> IDLE next cycle.
REQ-034 Illegal op: Ctrl1=100 -> response at N+1 with Id=1, Err=1, Res=0; oAluCtrl stays 000.
REQ-035 Reset mid-EXEC: assert iReset during EXEC -> next cycle IDLE, oRespValid=0, ptr=0; no response for discarded request.
REQ-036 SLT: A0=32'hDEADBEEF, B0=0, Ctrl0=111 -> operands passed unchanged to ALU, oRespRes equals iAluRes from EXEC cycle.
